// File: rtl/bcd_scan_mux.sv
// Four-digit packed-BCD scanner for a multiplexed 7-segment display.
// A double-buffered value is shown one digit per slot, with optional leading-zero blanking.
module bcd_scan_mux #(
   parameter int TICK_DIV = 12500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   input  logic        enable,
   output logic [3:0]  bcd,
   output logic [3:0]  digit,
   output logic        frame_done,
   output logic        bad_bcd
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [15:0]   active;
   logic [15:0]   pending;
   logic          pend_v;
   logic          tick;
   logic          boundary;
   logic [3:0]    lz;
   logic          blank;
   logic          any_bad;

   assign tick     = (presc == PW'(TICK_DIV - 1));
   assign boundary = tick && (idx == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= 2'd0;
      end else if (tick) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // load is a single-cycle strobe with no back-pressure: the most recent strobe
   // before a frame boundary is what gets shown, and a strobe on the boundary
   // cycle itself bypasses the pending buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 16'h0000;
         pending <= 16'h0000;
         pend_v  <= 1'b0;
      end else begin
         if (load) pending <= value;
         if (boundary) begin
            pend_v <= 1'b0;
            if (load)        active <= value;
            else if (pend_v) active <= pending;
         end else if (load) begin
            pend_v <= 1'b1;
         end
      end
   end

   // lz[i]: nibbles i..3 are all zero, so slot i is a leading zero
   always_comb begin
      lz[3]   = (active[15:12] == 4'h0);
      lz[2]   = lz[3] && (active[11:8] == 4'h0);
      lz[1]   = lz[2] && (active[7:4] == 4'h0);
      lz[0]   = 1'b0;
      blank   = !enable || (blank_lz && lz[idx]);
      any_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (active[4*i +: 4] > 4'd9) any_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd        <= 4'h0;
         digit      <= 4'b1111;
         frame_done <= 1'b0;
         bad_bcd    <= 1'b0;
      end else begin
         bcd        <= active[{idx, 2'b00} +: 4];
         digit      <= blank ? 4'b1111 : ~(4'b0001 << idx);
         frame_done <= boundary;
         bad_bcd    <= any_bad;
      end
   end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux at TICK_DIV=4: display table, random traffic against an
// arithmetic cycle model, load-on-boundary and mid-frame reset sequences.
module tb_bcd_scan_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic        blank_lz;
   logic        enable;
   logic [3:0]  bcd;
   logic [3:0]  digit;
   logic        frame_done;
   logic        bad_bcd;

   int n_vec = 0;
   int n_err = 0;

   // reference model: time since reset plus the two buffers
   int          m_t;
   logic [15:0] m_active;
   logic [15:0] m_pend;
   logic        m_pv;
   logic [3:0]  e_bcd;
   logic [3:0]  e_dig;
   logic        e_fd;
   logic        e_bad;

   typedef struct {
      logic [15:0] value;
      logic        blz;
      logic        en;
      logic [15:0] exp_bcd;  // slot3..slot0
      logic [15:0] exp_dig;  // slot3..slot0
      logic        exp_bad;
   } vec_t;

   vec_t tbl[7];

   bcd_scan_mux #(.TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .blank_lz(blank_lz), .enable(enable), .bcd(bcd), .digit(digit),
      .frame_done(frame_done), .bad_bcd(bad_bcd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] model_digit(input logic [15:0] a, input int slot,
                                              input logic blz, input logic en);
      if (!en) return 4'b1111;
      if (blz && slot > 0 && (a >> (4 * slot)) == 16'h0) return 4'b1111;
      return 4'hF & ~(4'(1) << slot);
   endfunction

   function automatic logic model_bad(input logic [15:0] a);
      for (int i = 0; i < 4; i++) if (((a >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_t = 0; m_active = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
   endtask

   // one clock: drive at negedge, advance model at posedge, compare at next negedge
   task automatic cyc(input logic ld, input logic [15:0] v, input logic blz, input logic en);
      int   slot;
      logic bnd;
      load = ld; value = v; blank_lz = blz; enable = en;
      @(posedge clk);
      slot  = (m_t / 4) % 4;
      bnd   = (m_t % 16) == 15;
      e_bcd = 4'((m_active >> (4 * slot)) & 16'hF);
      e_dig = model_digit(m_active, slot, blz, en);
      e_fd  = bnd;
      e_bad = model_bad(m_active);
      if (bnd) begin
         if (ld) m_active = v;
         else if (m_pv) m_active = m_pend;
         m_pv = 1'b0;
      end else if (ld) begin
         m_pv = 1'b1;
      end
      if (ld) m_pend = v;
      m_t++;
      @(negedge clk);
      chk("bcd", 16'(bcd), 16'(e_bcd));
      chk("digit", 16'(digit), 16'(e_dig));
      chk("frame_done", 16'(frame_done), 16'(e_fd));
      chk("bad_bcd", 16'(bad_bcd), 16'(e_bad));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bcd"}, 16'(bcd), 16'h0);
      chk({tag, "_digit"}, 16'(digit), 16'hF);
      chk({tag, "_frame_done"}, 16'(frame_done), 16'h0);
      chk({tag, "_bad_bcd"}, 16'(bad_bcd), 16'h0);
   endtask

   initial begin
      tbl[0] = '{16'h1234, 1'b0, 1'b1, 16'h1234, 16'h7BDE, 1'b0};
      tbl[1] = '{16'h0042, 1'b1, 1'b1, 16'h0042, 16'hFFDE, 1'b0};
      tbl[2] = '{16'h0042, 1'b0, 1'b1, 16'h0042, 16'h7BDE, 1'b0};
      tbl[3] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 16'hFFFE, 1'b0};
      tbl[4] = '{16'h9A00, 1'b0, 1'b1, 16'h9A00, 16'h7BDE, 1'b1};
      tbl[5] = '{16'h5678, 1'b0, 1'b0, 16'h5678, 16'hFFFF, 1'b0};
      tbl[6] = '{16'h0100, 1'b1, 1'b1, 16'h0100, 16'hFBDE, 1'b0};

      rst_n = 1'b0; load = 1'b0; value = 16'h0; blank_lz = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      model_reset();
      rst_n = 1'b1;

      // idle frames after reset
      for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);

      // table: load, wait for the committing boundary, then inspect each slot
      foreach (tbl[n]) begin
         logic got;
         cyc(1'b1, tbl[n].value, tbl[n].blz, tbl[n].en);
         got = frame_done;
         for (int w = 0; w < 40 && !got; w++) begin
            cyc(1'b0, 16'h0, tbl[n].blz, tbl[n].en);
            got = frame_done;
         end
         chk("commit_timeout", 16'(got), 16'h1);
         for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0, tbl[n].blz, tbl[n].en);
            chk("tbl_bcd", 16'(bcd), 16'(tbl[n].exp_bcd[4*k +: 4]));
            chk("tbl_digit", 16'(digit), 16'(tbl[n].exp_dig[4*k +: 4]));
            chk("tbl_bad", 16'(bad_bcd), 16'(tbl[n].exp_bad));
            for (int j = 0; j < 3; j++) cyc(1'b0, 16'h0, tbl[n].blz, tbl[n].en);
         end
      end

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [15:0] v;
         v = ($urandom_range(0, 3) == 0) ? 16'($urandom)
             : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
         cyc(($urandom_range(0, 7) == 0), v, 1'($urandom), ($urandom_range(0, 5) != 0));
      end

      // load exactly on the boundary cycle commits that same cycle
      for (int w = 0; w < 20 && (m_t % 16) != 15; w++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
      cyc(1'b1, 16'h8765, 1'b0, 1'b1);
      chk("bnd_load_fd", 16'(frame_done), 16'h1);
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      chk("bnd_load_bcd", 16'(bcd), 16'h5);
      chk("bnd_load_digit", 16'(digit), 16'hE);

      // reset mid-frame with a pending load
      for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
      cyc(1'b1, 16'h4321, 1'b0, 1'b1);
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 36; i++) begin
         cyc(1'b0, 16'h0, 1'b0, 1'b1);
         chk("post_reset_bcd", 16'(bcd), 16'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
